// File: rtl/i2d_bus_arb.sv
// Shares the core Wishbone master port between instruction fetch (IF) and load/store (LS).
// LS has fixed priority, IF has an anti-starvation limit, and slave retries are bounded.
// Optional watchdog enabled by I2D_ARB_TIMEOUT_EN.
module i2d_bus_arb #(
  parameter int unsigned RETRY_MAX   = 4,
  parameter int unsigned STARVE_LIM  = 3
`ifdef I2D_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  output logic [31:0] if_dat,
  output logic        if_ack,
  output logic        if_err,
  output logic        if_busy,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [3:0]  ls_sel,
  input  logic [31:0] ls_adr,
  input  logic [31:0] ls_wdat,
  output logic [31:0] ls_rdat,
  output logic        ls_ack,
  output logic        ls_err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        rty_i,
  input  logic        err_i
);

  localparam int unsigned RW = (RETRY_MAX  > 0) ? $clog2(RETRY_MAX + 1)  : 1;
  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_LS, RETRY} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_gnt_ls;
  logic [RW-1:0] r_retry_cnt;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;

  logic w_bus;
  logic w_gnt_ls;
  logic w_gnt_if;
  logic w_t_err;
  logic w_t_ack;
  logic w_t_rty;
  logic w_tmo;
  logic w_rty_fail;
  logic w_done_err;
  logic w_done;

  assign w_bus = (r_state == BUS_IF) || (r_state == BUS_LS);

  // LS wins in IDLE unless IF has already been passed over STARVE_LIM times.
  assign w_gnt_ls = (r_state == IDLE) && ls_req &&
                    !(if_req && (r_starve == SW'(STARVE_LIM)));
  assign w_gnt_if = (r_state == IDLE) && if_req && !w_gnt_ls;

  assign w_t_err = w_bus && err_i;
  assign w_t_ack = w_bus && ack_i && !err_i;
  assign w_t_rty = w_bus && rty_i && !err_i && !ack_i;

`ifdef I2D_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (!rst || !w_bus) r_wdog <= '0;
    else                r_wdog <= r_wdog + TW'(1);
  end

  assign w_tmo = w_bus && (r_wdog == TW'(TIMEOUT_CYC)) && !err_i && !ack_i && !rty_i;
`else
  assign w_tmo = 1'b0;
`endif

  assign w_rty_fail = (r_state == RETRY) && (r_retry_cnt >= RW'(RETRY_MAX));
  assign w_done_err = w_t_err || w_tmo || w_rty_fail;
  assign w_done     = w_done_err || w_t_ack;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_ls)      w_next = BUS_LS;
        else if (w_gnt_if) w_next = BUS_IF;
      end
      BUS_IF, BUS_LS: begin
        if (w_done)       w_next = IDLE;
        else if (w_t_rty) w_next = RETRY;
      end
      RETRY: begin
        if (w_rty_fail)    w_next = IDLE;
        else if (r_gnt_ls) w_next = BUS_LS;
        else               w_next = BUS_IF;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt_ls    <= 1'b0;
      r_retry_cnt <= '0;
      r_starve    <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_ls) begin
        r_gnt_ls <= 1'b1;
        r_adr    <= ls_adr;
        r_dat    <= ls_wdat;
        r_sel    <= ls_sel;
        r_we     <= ls_we;
      end else if (w_gnt_if) begin
        r_gnt_ls <= 1'b0;
        r_adr    <= if_adr;
        r_dat    <= '0;
        r_sel    <= 4'hF;
        r_we     <= 1'b0;
      end
      if (w_gnt_if || !if_req) r_starve <= '0;
      else if (w_gnt_ls)       r_starve <= r_starve + SW'(1);
      if (w_done)              r_retry_cnt <= '0;
      else if (w_t_rty)        r_retry_cnt <= r_retry_cnt + RW'(1);
    end
  end

  assign cyc_o = w_bus && !w_tmo;
  assign stb_o = cyc_o;
  assign we_o  = r_we;
  assign sel_o = r_sel;
  assign adr_o = r_adr;
  assign dat_o = r_dat;

  // Terminations are masked while reset is held so a requester never sees one.
  assign if_ack  = rst && !r_gnt_ls && w_t_ack;
  assign if_err  = rst && !r_gnt_ls && w_done_err;
  assign ls_ack  = rst &&  r_gnt_ls && w_t_ack;
  assign ls_err  = rst &&  r_gnt_ls && w_done_err;
  assign if_dat  = dat_i;
  assign ls_rdat = dat_i;
  assign if_busy = if_req && !if_ack && !if_err;

endmodule

// File: tb/tb_i2d_bus_arb.sv
// Directed bench for i2d_bus_arb: reset, IF read, contention, retries, error priority,
// reset mid-transfer and (with I2D_ARB_TIMEOUT_EN) the watchdog.
module tb_i2d_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_adr, ls_adr, ls_wdat, dat_i;
  logic [3:0]  ls_sel;
  logic        ack_i, rty_i, err_i;
  logic [31:0] if_dat, ls_rdat, adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        if_ack, if_err, if_busy, ls_ack, ls_err, cyc_o, stb_o, we_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  i2d_bus_arb #(.RETRY_MAX(4), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_dat(if_dat), .if_ack(if_ack),
    .if_err(if_err), .if_busy(if_busy),
    .ls_req(ls_req), .ls_we(ls_we), .ls_sel(ls_sel), .ls_adr(ls_adr),
    .ls_wdat(ls_wdat), .ls_rdat(ls_rdat), .ls_ack(ls_ack), .ls_err(ls_err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .rty_i(rty_i), .err_i(err_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // LS write at 0x200/sel 3; slave retries the first nrty bus cycles, then acks.
  task automatic run_ls_retry(input int unsigned nrty, output int unsigned rtys,
                              output int unsigned gaps, output int unsigned errs,
                              output int unsigned acks);
    logic started;
    logic done;
    rtys = 0; gaps = 0; errs = 0; acks = 0;
    started = 1'b0; done = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_sel = 4'h3; ls_adr = 32'h200; ls_wdat = 32'h1234_5678;
    dat_i = 32'hCAFE_F00D;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (cyc_o && !started) begin
        started = 1'b1;
        check("ls_we_o", {31'b0, we_o}, 32'd1);
        check("ls_sel_o", {28'b0, sel_o}, 32'h3);
        check("ls_adr_o", adr_o, 32'h200);
        check("ls_dat_o", dat_o, 32'h1234_5678);
      end
      if (started && !cyc_o) gaps++;
      rty_i = cyc_o && (rtys < nrty);
      ack_i = cyc_o && (rtys >= nrty);
      if (rty_i) rtys++;
      #1;
      if (ls_err) errs++;
      if (ls_ack) begin
        acks++;
        check("ls_rdat", ls_rdat, 32'hCAFE_F00D);
      end
      if (ls_err || ls_ack) begin
        done = 1'b1;
        ls_req = 1'b0;
      end
    end
    check("retry_done", {31'b0, done}, 32'd1);
    @(posedge clk);
    #1;
    rty_i = 1'b0; ack_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned rtys, gaps, errs, acks, gcount;
    logic [7:0] grants;
    logic [7:0] exp_gnt;
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_adr = '0; ls_adr = '0; ls_wdat = '0; ls_sel = '0; dat_i = '0;
    ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'b0, cyc_o}, 32'd0);
    check("rst_adr", adr_o, 32'd0);
    check("rst_sel", {28'b0, sel_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // IF read
    if_req = 1'b1; if_adr = 32'h100;
    #1;
    check("if_idle_cyc", {31'b0, cyc_o}, 32'd0);
    check("if_busy_pend", {31'b0, if_busy}, 32'd1);
    @(negedge clk);
    check("if_cyc", {30'b0, cyc_o, stb_o}, 32'h3);
    check("if_adr_o", adr_o, 32'h100);
    check("if_we_sel", {27'b0, we_o, sel_o}, 32'h0F);
    ack_i = 1'b1; dat_i = 32'hDEAD_BEEF;
    #1;
    check("if_ack", {31'b0, if_ack}, 32'd1);
    check("if_dat", if_dat, 32'hDEAD_BEEF);
    check("if_ls_ack", {31'b0, ls_ack}, 32'd0);
    check("if_busy_done", {31'b0, if_busy}, 32'd0);
    @(negedge clk);
    ack_i = 1'b0; if_req = 1'b0;
    #1;
    check("if_cyc_drop", {31'b0, cyc_o}, 32'd0);
    check("if_ack_drop", {31'b0, if_ack}, 32'd0);
    @(negedge clk);

    // Contention: expect LS,LS,LS,IF,LS,LS,LS,IF
    exp_gnt = 8'b0111_0111;
    grants = '0; gcount = 0;
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_sel = 4'hF;
    if_adr = 32'h100; ls_adr = 32'h300;
    for (int c = 0; c < 80 && gcount < 8; c++) begin
      @(negedge clk);
      ack_i = cyc_o;
      if (cyc_o) begin
        grants[gcount] = (adr_o == 32'h300);
        gcount++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("gnt_count", gcount, 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("gnt_%0d", i), {31'b0, grants[i]}, {31'b0, exp_gnt[i]});
    @(negedge clk);
    ack_i = 1'b0;
    @(negedge clk);

    // Retry exhaustion and retry-then-ack
    run_ls_retry(99, rtys, gaps, errs, acks);
    check("rf_rtys", rtys, 32'd4);
    check("rf_gaps", gaps, 32'd4);
    check("rf_errs", errs, 32'd1);
    check("rf_acks", acks, 32'd0);
    run_ls_retry(3, rtys, gaps, errs, acks);
    check("ra_rtys", rtys, 32'd3);
    check("ra_gaps", gaps, 32'd3);
    check("ra_errs", errs, 32'd0);
    check("ra_acks", acks, 32'd1);

    // err_i beats ack_i
    if_req = 1'b1; if_adr = 32'h140;
    @(negedge clk);
    check("ep_cyc", {31'b0, cyc_o}, 32'd1);
    ack_i = 1'b1; err_i = 1'b1;
    #1;
    check("ep_if_err", {31'b0, if_err}, 32'd1);
    check("ep_if_ack", {31'b0, if_ack}, 32'd0);
    check("ep_ls_err", {31'b0, ls_err}, 32'd0);
    if_req = 1'b0;
    @(posedge clk);
    #1;
    ack_i = 1'b0; err_i = 1'b0;
    @(negedge clk);
    check("ep_cyc_drop", {31'b0, cyc_o}, 32'd0);
    @(negedge clk);

    // Reset while in BUS_LS, slave acking during reset
    ls_req = 1'b1; ls_we = 1'b0; ls_adr = 32'h400;
    @(negedge clk);
    check("rm_cyc", {31'b0, cyc_o}, 32'd1);
    rst = 1'b0; ack_i = 1'b1;
    #1;
    check("rm_term", {30'b0, ls_ack, ls_err}, 32'd0);
    @(negedge clk);
    check("rm_cyc_drop", {31'b0, cyc_o}, 32'd0);
    check("rm_adr", adr_o, 32'd0);
    check("rm_term2", {30'b0, ls_ack, ls_err}, 32'd0);
    ack_i = 1'b0; ls_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rm_idle", {31'b0, cyc_o}, 32'd0);

`ifdef I2D_ARB_TIMEOUT_EN
    begin
      int unsigned k;
      logic seen;
      seen = 1'b0; k = 0;
      if_req = 1'b1; if_adr = 32'h180;
      @(negedge clk);
      check("to_cyc", {31'b0, cyc_o}, 32'd1);
      for (int c = 0; c < 200 && !seen; c++) begin
        #1;
        if (if_err) seen = 1'b1;
        else begin
          k++;
          @(negedge clk);
        end
      end
      check("to_seen", {31'b0, seen}, 32'd1);
      check("to_cycles", k, 32'd64);
      if_req = 1'b0;
      @(negedge clk);
      check("to_cyc_drop", {31'b0, cyc_o}, 32'd0);
      check("to_err_drop", {31'b0, if_err}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
